uart_hex_rx: RTL

UART receiver, 8N1, 115200 baud by default. It is the host-to-FPGA counterpart of the TDC result transmitter. It deframes serial bytes and parses lines of exactly 10 ASCII hex characters terminated by LF into a 40-bit word, for example a configuration or threshold value. It sits between the board RX pin and the control registers, and emits a one-cycle valid pulse per accepted line.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_rx_byte.sv | 82 ++++++++
 rtl/uart_hex_rx.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART/ASCII definitions: character constants, byte FSM encoding, hex decode.
// Pure definitions, no logic; latency and backpressure are properties of the users.
// Both the byte FSM and the line parser import this package.
package uart_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;

    localparam int HEX_DIGITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] nib;
    } hex_t;

    function automatic hex_t hex_decode(input logic [7:0] c);
        hex_t h;
        h.vld = 1'b1;
        h.nib = 4'd0;
        if (c >= ASCII_0 && c <= ASCII_0 + 8'd9)
            h.nib = 4'(c - ASCII_0);
        else if (c >= ASCII_UA && c <= ASCII_UA + 8'd5)
            h.nib = 4'(c - ASCII_UA + 8'd10);
        else if (c >= ASCII_LA && c <= ASCII_LA + 8'd5)
            h.nib = 4'(c - ASCII_LA + 8'd10);
        else
            h.vld = 1'b0;
        return h;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 deframer: 2-flop synchronizer plus start/data/stop bit FSM.
// Latency: byte_valid/frame_err are combinational in the mid-stop-bit sample cycle.
// No backpressure: the consumer must take byte_valid in the cycle it is high.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta;
    logic        rx_s;
    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        cnt_done;

    // The start bit is timed to its middle; all later bits are a full bit apart from there.
    assign cnt_done = (state == START) ? (clk_cnt == HALF_LAST) : (clk_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            clk_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_nxt;
            if (state == IDLE || cnt_done)
                clk_cnt <= 16'd0;
            else
                clk_cnt <= clk_cnt + 16'd1;
            if (state == IDLE)
                bit_idx <= 3'd0;
            else if (state == DATA && cnt_done) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (cnt_done) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (cnt_done && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (cnt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Returning to IDLE at mid-stop lets a zero-gap start edge be caught.
    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        busy       = (state != IDLE);
        if (state == STOP && cnt_done) begin
            byte_valid = rx_s;
            frame_err  = !rx_s;
        end
    end

    assign byte_data = shift_reg;

endmodule

// File: rtl/uart_hex_rx.sv
// UART line receiver: 10 hex chars + LF -> 40-bit data, one-cycle valid/error pulses.
// Latency: pulses one cycle after the mid-stop-bit sample of the terminating byte.
// No backpressure: data_valid is a single-cycle strobe with no ready.
module uart_hex_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [39:0] data,
    output logic        data_valid,
    output logic        frame_err,
    output logic        parse_err,
    output logic        busy
);

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [3:0] DIGITS_MAX   = 4'(HEX_DIGITS);

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ferr;
    hex_t        hx;
    logic [39:0] acc;
    logic [3:0]  digit_cnt;
    logic        line_bad;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (byte_ferr),
        .busy      (busy)
    );

    always_comb hx = hex_decode(byte_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= 40'd0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parse_err  <= 1'b0;
            acc        <= 40'd0;
            digit_cnt  <= 4'd0;
            line_bad   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parse_err  <= 1'b0;
            frame_err  <= byte_ferr;
            // A dropped byte poisons the rest of the line.
            if (byte_ferr) begin
                line_bad <= 1'b1;
            end else if (byte_valid) begin
                if (hx.vld) begin
                    if (digit_cnt < DIGITS_MAX) begin
                        acc       <= {acc[35:0], hx.nib};
                        digit_cnt <= digit_cnt + 4'd1;
                    end else begin
                        line_bad <= 1'b1;
                    end
                end else if (byte_data == ASCII_CR) begin
                    line_bad <= line_bad;
                end else if (byte_data == ASCII_LF) begin
                    if (digit_cnt == DIGITS_MAX && !line_bad) begin
                        data       <= acc;
                        data_valid <= 1'b1;
                    end else if (digit_cnt != 4'd0 || line_bad) begin
                        parse_err <= 1'b1;
                    end
                    acc       <= 40'd0;
                    digit_cnt <= 4'd0;
                    line_bad  <= 1'b0;
                end else begin
                    line_bad <= 1'b1;
                end
            end
        end
    end

endmodule
